// File: rtl/uart_tx_serializer_if.sv
// Parallel-side handshake for the UART transmit serializer: data plus valid/ready.
interface uart_tx_serializer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start bit, DATA_W bits LSB-first, optional even parity, stop bits.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx_serializer #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    uart_tx_serializer_if.slave    tx_if,
    output logic                   tx_serial,
    output logic                   tx_busy,
    output logic                   tx_done
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd4,
`endif
        ST_STOP   = 3'd3
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    baud_q, baud_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                stop_idx_q, stop_idx_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic                serial_q, serial_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                bit_end_s;

`ifdef UART_TX_PARITY_EN
    logic                parity_q, parity_d;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction
`endif

    assign bit_end_s      = (baud_q == BAUD_LAST);
    assign tx_if.tx_ready = (state_q == ST_IDLE);
    assign tx_serial      = serial_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;

    // Next-state logic: baud timing, bit sequencing and the registered line value.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        idx_d      = idx_q;
        stop_idx_d = stop_idx_q;
        shift_d    = shift_q;
        serial_d   = serial_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d   = parity_q;
`endif

        if (state_q == ST_IDLE) begin
            baud_d = {CNT_W{1'b0}};
        end else if (bit_end_s) begin
            baud_d = {CNT_W{1'b0}};
        end else begin
            baud_d = baud_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (tx_if.tx_valid) begin
                    state_d    = ST_START;
                    shift_d    = tx_if.tx_data;
                    idx_d      = {IDX_W{1'b0}};
                    stop_idx_d = 1'b0;
                    serial_d   = 1'b0;
                    busy_d     = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d   = even_parity(tx_if.tx_data);
`endif
                end else begin
                    serial_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    state_d  = ST_DATA;
                    serial_d = shift_q[0];
                end else begin
                    serial_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    shift_d = {1'b0, shift_q[DATA_W-1:1]};
                    if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d  = ST_PARITY;
                        serial_d = parity_q;
`else
                        state_d  = ST_STOP;
                        serial_d = 1'b1;
`endif
                    end else begin
                        idx_d    = idx_q + IDX_W'(1);
                        serial_d = shift_q[1];
                    end
                end else begin
                    serial_d = shift_q[0];
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end_s) begin
                    state_d  = ST_STOP;
                    serial_d = 1'b1;
                end else begin
                    serial_d = parity_q;
                end
            end
`endif
            ST_STOP: begin
                serial_d = 1'b1;
                if (bit_end_s) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end else begin
                    stop_idx_d = stop_idx_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                serial_d = 1'b1;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset forces the line high and aborts any frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            baud_q     <= {CNT_W{1'b0}};
            idx_q      <= {IDX_W{1'b0}};
            stop_idx_q <= 1'b0;
            shift_q    <= {DATA_W{1'b0}};
            serial_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            idx_q      <= idx_d;
            stop_idx_q <= stop_idx_d;
            shift_q    <= shift_d;
            serial_q   <= serial_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- UART transmit stage: accepts a parallel byte over a valid/ready handshake and serializes it onto tx_serial as start, data LSB-first, optional parity, then stop bits.
- Owns the baud-interval timing and the bit-position sequencing for the TX path.
- Sits between the bus-side TX register (upstream) and the physical TX pin (downstream).

Parameters:
- DATA_W, default 8: data bits per frame, legal range 5..9.
- CLKS_PER_BIT, default 434: clk cycles per bit, i.e. 50 MHz / 115200. Minimum 2.
- STOP_BITS, default 1: number of stop bits, 1 or 2.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset; 0 = reset asserted.
- tx_data  input  DATA_W  byte to send; sampled only at handshake.
- tx_valid  input  1  upstream has a byte.
- tx_ready  output  1  block can accept a byte (IDLE only).
- tx_serial  output  1  serial line; idles high.
- tx_busy  output  1  frame in progress (any state except IDLE).
- tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx_serial=1, tx_ready=1, tx_busy=0, tx_done=0, baud counter=0, bit index=0, shift register=0.
- Reset asserted mid-frame: line goes high immediately and the frame is aborted; there is no resume.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP.
- Handshake: a transfer occurs on a rising edge with state=IDLE and tx_valid=1.
  - tx_data is latched into the shift register and the state goes to START.
  - tx_serial drives 0 from the next cycle.
  - tx_data changes after acceptance have no effect.
- tx_ready is a combinational decode of state==IDLE. It is never high outside IDLE.
- Baud counter: width clog2(CLKS_PER_BIT).
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - At terminal count it wraps to 0 and the state or bit advances.
  - Every bit therefore lasts exactly CLKS_PER_BIT cycles.
- START: tx_serial=0 for one bit time, then DATA with bit index=0.
- DATA: tx_serial=shift_reg[0]. At each bit end the register shifts right and the index increments.
  - At index DATA_W-1 terminal, go to PARITY (macro on) or STOP.
- STOP: tx_serial=1 for STOP_BITS bit times. A stop-bit index counts the bits when STOP_BITS=2.
- Frame end: at the final STOP terminal count, state returns to IDLE and tx_done=1 for exactly that one cycle (the first IDLE cycle). tx_busy falls the same cycle.
- Frame length: (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with the macro and 0 without.
  - Measured from the first START cycle to the last STOP cycle.
  - tx_done asserts the cycle after the last STOP cycle.
- Back-to-back: with tx_valid held high, the next byte is accepted in the IDLE cycle carrying tx_done. The line therefore stays high one extra clk between frames.
- tx_valid while busy: ignored and not queued; upstream holds it until tx_ready.
- tx_serial is driven from a register, so there are no glitches.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state inserted after DATA for one bit time. tx_serial = XOR of the latched data bits (even parity), computed at acceptance and held in a register.
- Undefined: PARITY state and parity register are not synthesized. DATA goes directly to STOP.

Test Plan:
- Reset check: rst=0 mid-DATA of a frame -> tx_serial=1, tx_busy=0, tx_ready=1 immediately (no clk edge). After rst=1, no further frame activity until a new tx_valid.
- Basic frame, CLKS_PER_BIT=4, macro off, send 0xA5:
  - tx_serial per 4-cycle slot = 0,1,0,1,0,0,1,0,1,1.
  - tx_done pulses exactly 40 cycles after the first START cycle.
- Parity, macro on, CLKS_PER_BIT=4:
  - 0xA5 -> parity slot=0, 44-cycle frame.
  - 0x07 -> parity slot=1.
- STOP_BITS=2, send 0xFF -> line high for 8 cycles after data; tx_done 44 cycles after START (macro off).
- Back-to-back, tx_valid held high with 0x3C then 0xC3:
  - second START begins the cycle after tx_done.
  - exactly 1 extra high cycle between frames.
  - tx_ready low throughout each frame.
- Data stability: change tx_data every cycle during a frame of 0x55 -> serialized bits remain 1,0,1,0,1,0,1,0.
